// File: rtl/exe_wb_stage.sv
// rtl/exe_wb_stage.sv - execute-to-writeback buffer: CPSR flag commit plus in-order writeback FIFO (optional EXE_WB_FWD_EN forwarding)
module exe_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [DATA_W:0]            ex_result,
    input  logic [31:0]                ex_cpsr,
    input  logic                       ex_set_flags,
    input  logic [ADDR_W-1:0]          ex_rd,
    input  logic                       ex_rd_we,
    input  logic                       flush,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [ADDR_W-1:0]          wb_rd,
    output logic [DATA_W-1:0]          wb_data,
    output logic [31:0]                cpsr,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef EXE_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]          fwd_rs,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
    logic [ADDR_W-1:0] mem_rd_d   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              accept, push, pop;

    // Carry-out and the low CPSR bits are never consumed here.
    logic unused_bits;
    assign unused_bits = ^{ex_result[DATA_W], ex_cpsr[27:0]};

    // Handshake and registered outputs; ex_ready depends on occupancy only.
    assign ex_ready = (count_q < CNT_W'(DEPTH));
    assign wb_valid = (count_q != '0);
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign cpsr     = {nzcv_q, 28'd0};
    assign count    = count_q;
    assign accept   = ex_valid & ex_ready & ~flush;
    assign push     = accept & ex_rd_we;
    assign pop      = wb_valid & wb_ready;

    // Next FIFO state, flag commit and the head entry to present next cycle.
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        nzcv_d     = nzcv_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (accept && ex_set_flags) begin
            nzcv_d = ex_cpsr[31:28];
        end
        if (push) begin
            mem_rd_d[wr_ptr_q]   = ex_rd;
            mem_data_d[wr_ptr_q] = ex_result[DATA_W-1:0];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        // Head output registers follow the new head; they hold when the FIFO empties.
        if (count_d != '0) begin
            wb_rd_d   = mem_rd_d[rd_ptr_d];
            wb_data_d = mem_data_d[rd_ptr_d];
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            nzcv_q    <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            nzcv_q     <= nzcv_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

`ifdef EXE_WB_FWD_EN
    // Search buffered entries oldest to youngest so the youngest match overrides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem_rd_q[idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_exe_wb_stage.sv
// tb/tb_exe_wb_stage.sv - scoreboard bench for exe_wb_stage
module tb_exe_wb_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid, ex_ready, ex_set_flags, ex_rd_we, flush;
    logic [DATA_W:0]   ex_result;
    logic [31:0]       ex_cpsr, cpsr;
    logic [ADDR_W-1:0] ex_rd, wb_rd;
    logic              wb_valid, wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fwd_rs;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [ADDR_W+DATA_W-1:0] sb_q[$];
    logic [3:0]               m_nzcv;
    logic [ADDR_W+DATA_W-1:0] m_last;

    exe_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_cpsr(ex_cpsr), .ex_set_flags(ex_set_flags), .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .cpsr(cpsr), .count(count)
`ifdef EXE_WB_FWD_EN
        , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W:0] res,
                         input logic [31:0] cp, input logic sf, input logic we,
                         input logic fl, input logic wr);
        ex_valid = v; ex_rd = rd; ex_result = res; ex_cpsr = cp;
        ex_set_flags = sf; ex_rd_we = we; flush = fl; wb_ready = wr;
    endtask

    task automatic idle(input logic wr);
        drive(1'b0, '0, '0, 32'h0, 1'b0, 1'b0, 1'b0, wr);
    endtask

    // Check all outputs at the falling edge against the model, then advance the model at the rising edge.
    task automatic step(output logic acc);
        logic [ADDR_W+DATA_W-1:0] head;
        logic                     pop, e_hit;
        logic [DATA_W-1:0]        e_fdata;
        @(negedge clk);
        chk("ex_ready", ex_ready, sb_q.size() < DEPTH);
        chk("wb_valid", wb_valid, sb_q.size() != 0);
        chk("count", count, sb_q.size());
        chk("cpsr", cpsr, {m_nzcv, 28'd0});
        head = (sb_q.size() != 0) ? sb_q[0] : m_last;
        m_last = head;
        chk("wb_rd", wb_rd, head[ADDR_W+DATA_W-1:DATA_W]);
        chk("wb_data", wb_data, head[DATA_W-1:0]);
`ifdef EXE_WB_FWD_EN
        e_hit = 1'b0;
        e_fdata = '0;
        foreach (sb_q[i]) begin
            if (sb_q[i][ADDR_W+DATA_W-1:DATA_W] == fwd_rs) begin
                e_hit = 1'b1;
                e_fdata = sb_q[i][DATA_W-1:0];
            end
        end
        chk("fwd_hit", fwd_hit, e_hit);
        chk("fwd_data", fwd_data, e_fdata);
`else
        e_hit = 1'b0;
        e_fdata = '0;
`endif
        acc = ex_valid & (sb_q.size() < DEPTH) & ~flush;
        pop = (sb_q.size() != 0) & wb_ready;
        if (pop) void'(sb_q.pop_front());
        if (flush) sb_q.delete();
        if (acc && ex_rd_we) sb_q.push_back({ex_rd, ex_result[DATA_W-1:0]});
        if (acc && ex_set_flags) m_nzcv = ex_cpsr[31:28];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        m_nzcv = '0;
        m_last = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic acc;
    int   tries;

    initial begin
        fwd_rs = '0;
        idle(1'b1);
        do_reset();
        step(acc);

        // single op rd=3 data=5
        drive(1'b1, 4'd3, 33'h0_0000_0005, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(acc);
        idle(1'b1);
        repeat (2) step(acc);

        // back-to-back with writeback stalled, third op held until space frees
        for (int op = 1; op <= 3; op++) begin
            tries = 0;
            do begin
                drive(1'b1, ADDR_W'(op), 33'(32'h1100 + op), 32'h0, 1'b0, 1'b1, 1'b0, tries >= 3);
                step(acc);
                tries++;
            end while (!acc && tries < 20);
            chk("held_op_accepted", acc, 1'b1);
        end
        idle(1'b1);
        repeat (4) step(acc);

        // flags-only ops
        drive(1'b1, 4'd0, '0, 32'h6000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step(acc);
        drive(1'b1, 4'd0, '0, 32'hF000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(acc);
        idle(1'b1);
        step(acc);

        // flush with two buffered entries and a flag-setting incoming op
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, ADDR_W'(7 + k), 33'(32'hAA00 + k), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(acc);
        end
        drive(1'b1, 4'd9, 33'h1_0000_BEEF, 32'h9000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        step(acc);
        idle(1'b1);
        repeat (2) step(acc);

        // full FIFO: push refused while popping, then push+pop keeps count at 1
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, ADDR_W'(10 + k), 33'(32'h5500 + k), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(acc);
        end
        drive(1'b1, 4'd12, 33'h5502, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(acc);
        chk("full_push_refused", acc, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ADDR_W'(12 + k), 33'(32'h5502 + k), 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            step(acc);
        end
        idle(1'b1);
        repeat (2) step(acc);

        // random traffic exercising wrap, flags and occasional flush
        for (int n = 0; n < 300; n++) begin
            fwd_rs = ADDR_W'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 3)),
                  {1'($urandom), 32'($urandom)}, 32'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 15) == 0, 1'($urandom));
            step(acc);
        end
        idle(1'b1);
        repeat (3) step(acc);

        // forwarding: youngest match wins
        drive(1'b1, 4'd4, 33'h0000A, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(acc);
        drive(1'b1, 4'd4, 33'h0000B, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(acc);
        idle(1'b0);
        fwd_rs = 4'd4;
        step(acc);
        fwd_rs = 4'd5;
        step(acc);

        // asynchronous reset mid-drain
        drive(1'b0, '0, '0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(acc);
        chk("pre_reset_valid", wb_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", wb_valid, 1'b0);
        chk("arst_count", count, '0);
        chk("arst_ex_ready", ex_ready, 1'b1);
        chk("arst_wb_rd", wb_rd, '0);
        chk("arst_wb_data", wb_data, '0);
        chk("arst_cpsr", cpsr, '0);
`ifdef EXE_WB_FWD_EN
        fwd_rs = 4'd4;
        #1;
        chk("arst_fwd_hit", fwd_hit, 1'b0);
`endif
        do_reset();
        step(acc);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
